// File: rtl/rpn_pilha_controle_if.sv
// Handshake/data bundle between the RPN stack sequencer and its
// surroundings (button pulses in, ALU operands/result, status out).
interface rpn_pilha_controle_if #(
  parameter int LARGURA      = 8,
  parameter int PROFUNDIDADE = 4
);
  localparam int NW = $clog2(PROFUNDIDADE + 1);

  logic               enter_pulso;
  logic               executar_pulso;
  logic               limpar_pulso;
  logic [LARGURA-1:0] dado_entrada;
  logic [2:0]         codigo_op;
  logic [LARGURA-1:0] alu_resultado;
  logic [LARGURA-1:0] alu_a;
  logic [LARGURA-1:0] alu_b;
  logic [2:0]         alu_op;
  logic [LARGURA-1:0] topo;
  logic [NW-1:0]      nivel;
  logic               ocupado;
  logic               resultado_valido;
  logic               erro_overflow;
  logic               erro_underflow;

  modport master (
    output enter_pulso, executar_pulso, limpar_pulso, dado_entrada, codigo_op,
           alu_resultado,
    input  alu_a, alu_b, alu_op, topo, nivel, ocupado, resultado_valido,
           erro_overflow, erro_underflow
  );

  modport slave (
    input  enter_pulso, executar_pulso, limpar_pulso, dado_entrada, codigo_op,
           alu_resultado,
    output alu_a, alu_b, alu_op, topo, nivel, ocupado, resultado_valido,
           erro_overflow, erro_underflow
  );
endinterface

// File: rtl/rpn_pilha_controle.sv
// RPN operand stack sequencer: pushes operands, feeds the two topmost
// entries to an external ALU and writes the result back in their place.
module rpn_pilha_controle #(
  parameter int LARGURA      = 8,
  parameter int PROFUNDIDADE = 4,
  parameter int LATENCIA_ALU = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rpn_pilha_controle_if.slave   bus
);
  localparam int NW = $clog2(PROFUNDIDADE + 1);
  localparam int IW = $clog2(PROFUNDIDADE);
  localparam int CW = $clog2(LATENCIA_ALU + 1);
  localparam logic [NW-1:0] CHEIO = NW'(PROFUNDIDADE);
  localparam logic [NW-1:0] DOIS  = NW'(2);

  typedef enum logic {OCIOSO, OPERA} estado_t;

  estado_t                              estado;
  logic [PROFUNDIDADE-1:0][LARGURA-1:0] pilha;
  logic [NW-1:0]                        nivel;
  logic [CW-1:0]                        cnt;
  logic [LARGURA-1:0]                   alu_a, alu_b;
  logic [2:0]                           alu_op;
  logic                                 ocupado, resultado_valido;
  logic                                 erro_overflow, erro_underflow;
  logic [IW-1:0]                        idx_livre, idx_topo, idx_seg;

  // Indices wrap when nivel is out of range; every use is guarded by nivel.
  assign idx_livre = IW'(nivel);
  assign idx_topo  = IW'(nivel - NW'(1));
  assign idx_seg   = IW'(nivel - DOIS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado           <= OCIOSO;
      pilha            <= '0;
      nivel            <= '0;
      cnt              <= '0;
      alu_a            <= '0;
      alu_b            <= '0;
      alu_op           <= '0;
      ocupado          <= 1'b0;
      resultado_valido <= 1'b0;
      erro_overflow    <= 1'b0;
      erro_underflow   <= 1'b0;
    end else begin
      resultado_valido <= 1'b0;
      if (bus.limpar_pulso) begin
        // Aborts any in-flight operation; stack contents are left as-is.
        nivel          <= '0;
        erro_overflow  <= 1'b0;
        erro_underflow <= 1'b0;
        estado         <= OCIOSO;
        ocupado        <= 1'b0;
      end else begin
        case (estado)
          OCIOSO: begin
            if (bus.executar_pulso) begin
              if (nivel >= DOIS) begin
                alu_a   <= pilha[idx_seg];
                alu_b   <= pilha[idx_topo];
                alu_op  <= bus.codigo_op;
                cnt     <= CW'(LATENCIA_ALU);
                estado  <= OPERA;
                ocupado <= 1'b1;
              end else begin
                erro_underflow <= 1'b1;
              end
            end else if (bus.enter_pulso) begin
              if (nivel < CHEIO) begin
                pilha[idx_livre] <= bus.dado_entrada;
                nivel            <= nivel + NW'(1);
              end else begin
                erro_overflow <= 1'b1;
              end
            end
          end
          OPERA: begin
            cnt <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              pilha[idx_seg]   <= bus.alu_resultado;
              nivel            <= nivel - NW'(1);
              resultado_valido <= 1'b1;
              estado           <= OCIOSO;
              ocupado          <= 1'b0;
            end
          end
        endcase
      end
    end
  end

  assign bus.alu_a            = alu_a;
  assign bus.alu_b            = alu_b;
  assign bus.alu_op           = alu_op;
  assign bus.topo             = (nivel != '0) ? pilha[idx_topo] : '0;
  assign bus.nivel            = nivel;
  assign bus.ocupado          = ocupado;
  assign bus.resultado_valido = resultado_valido;
  assign bus.erro_overflow    = erro_overflow;
  assign bus.erro_underflow   = erro_underflow;
endmodule

// File: tb/tb_rpn_pilha_controle.sv
// Bench for rpn_pilha_controle: vector table of two-operand ops plus
// hand sequences for overflow, underflow, abort and long ALU latency.
module tb_rpn_pilha_controle;
  localparam int W = 8;
  localparam int P = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  rpn_pilha_controle_if #(.LARGURA(W), .PROFUNDIDADE(P)) b1 ();
  rpn_pilha_controle_if #(.LARGURA(W), .PROFUNDIDADE(P)) b3 ();

  rpn_pilha_controle #(.LARGURA(W), .PROFUNDIDADE(P), .LATENCIA_ALU(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1));
  rpn_pilha_controle #(.LARGURA(W), .PROFUNDIDADE(P), .LATENCIA_ALU(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .bus(b3));

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  assign b1.alu_resultado = alu_f(b1.alu_a, b1.alu_b, b1.alu_op);
  assign b3.alu_resultado = alu_f(b3.alu_a, b3.alu_b, b3.alu_op);

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] q1[$];
  logic [W-1:0] q3[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: each result pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (b1.resultado_valido) begin
      if (q1.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rv1_unexpected: got pulse topo=%0h expected no pulse", b1.topo);
      end else chk("res1", b1.topo, q1.pop_front());
    end
    if (b3.resultado_valido) begin
      if (q3.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL rv3_unexpected: got pulse topo=%0h expected no pulse", b3.topo);
      end else chk("res3", b3.topo, q3.pop_front());
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push1(input logic [W-1:0] d);
    b1.dado_entrada = d; b1.enter_pulso = 1'b1; step(); b1.enter_pulso = 1'b0;
  endtask

  task automatic exec1(input logic [2:0] op);
    b1.codigo_op = op; b1.executar_pulso = 1'b1; step(); b1.executar_pulso = 1'b0;
  endtask

  task automatic limpar1();
    b1.limpar_pulso = 1'b1; step(); b1.limpar_pulso = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic [W-1:0] res;
  } vec_t;

  vec_t tab[6];

  initial begin
    tab[0] = '{8'h05, 8'h03, 3'd0, 8'h08};
    tab[1] = '{8'h10, 8'h01, 3'd1, 8'h0F};
    tab[2] = '{8'hF0, 8'h3C, 3'd2, 8'h30};
    tab[3] = '{8'h0F, 8'h30, 3'd3, 8'h3F};
    tab[4] = '{8'hFF, 8'hAA, 3'd4, 8'h55};
    tab[5] = '{8'hC8, 8'h64, 3'd0, 8'h2C};

    {b1.enter_pulso, b1.executar_pulso, b1.limpar_pulso} = '0;
    {b3.enter_pulso, b3.executar_pulso, b3.limpar_pulso} = '0;
    b1.dado_entrada = '0; b1.codigo_op = '0;
    b3.dado_entrada = '0; b3.codigo_op = '0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    step(); step();
    chk("rst_nivel", b1.nivel, 0);
    chk("rst_topo", b1.topo, 0);
    chk("rst_ocupado", b1.ocupado, 0);
    chk("rst_rv", b1.resultado_valido, 0);
    chk("rst_flags", {b1.erro_overflow, b1.erro_underflow}, 0);
    chk("rst_alu", {b1.alu_a, b1.alu_b, b1.alu_op}, 0);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 6; i++) begin
      push1(tab[i].a);
      chk("v_nivel1", b1.nivel, 1);
      chk("v_topo_a", b1.topo, tab[i].a);
      push1(tab[i].b);
      chk("v_nivel2", b1.nivel, 2);
      chk("v_topo_b", b1.topo, tab[i].b);
      q1.push_back(tab[i].res);
      exec1(tab[i].op);
      chk("v_ocupado", b1.ocupado, 1);
      chk("v_alu_a", b1.alu_a, tab[i].a);
      chk("v_alu_b", b1.alu_b, tab[i].b);
      chk("v_alu_op", b1.alu_op, tab[i].op);
      chk("v_rv_early", b1.resultado_valido, 0);
      step();
      chk("v_ocupado_done", b1.ocupado, 0);
      chk("v_nivel_res", b1.nivel, 1);
      chk("v_topo_res", b1.topo, tab[i].res);
      chk("v_rv", b1.resultado_valido, 1);
      step();
      chk("v_rv_pulse", b1.resultado_valido, 0);
      limpar1();
      chk("v_clr_nivel", b1.nivel, 0);
      chk("v_clr_topo", b1.topo, 0);
    end

    // Overflow and clear
    push1(8'h11); push1(8'h22); push1(8'h33); push1(8'h44);
    chk("ov_nivel_full", b1.nivel, 4);
    chk("ov_flag_before", b1.erro_overflow, 0);
    push1(8'hAA);
    chk("ov_flag", b1.erro_overflow, 1);
    chk("ov_nivel", b1.nivel, 4);
    chk("ov_topo", b1.topo, 8'h44);
    step();
    chk("ov_sticky", b1.erro_overflow, 1);
    limpar1();
    chk("ov_clr_nivel", b1.nivel, 0);
    chk("ov_clr_flag", b1.erro_overflow, 0);
    chk("ov_clr_topo", b1.topo, 0);

    // Underflow with one entry
    push1(8'h07);
    exec1(3'd0);
    chk("un_flag", b1.erro_underflow, 1);
    chk("un_nivel", b1.nivel, 1);
    chk("un_ocupado", b1.ocupado, 0);
    chk("un_topo", b1.topo, 8'h07);
    step();
    chk("un_ocupado2", b1.ocupado, 0);
    limpar1();
    chk("un_clr_flag", b1.erro_underflow, 0);

    // enter and executar together: executar wins, pushed value dropped
    push1(8'h02); push1(8'h09);
    b1.dado_entrada = 8'hFF; b1.codigo_op = 3'd0;
    b1.enter_pulso = 1'b1; b1.executar_pulso = 1'b1;
    q1.push_back(8'h0B);
    step();
    b1.enter_pulso = 1'b0; b1.executar_pulso = 1'b0;
    chk("ee_ocupado", b1.ocupado, 1);
    chk("ee_nivel", b1.nivel, 2);
    step();
    chk("ee_nivel_res", b1.nivel, 1);
    chk("ee_topo", b1.topo, 8'h0B);
    limpar1();

    // limpar during OPERA aborts the write
    push1(8'h01); push1(8'h02);
    exec1(3'd0);
    chk("ab_ocupado", b1.ocupado, 1);
    limpar1();
    chk("ab_nivel", b1.nivel, 0);
    chk("ab_ocupado2", b1.ocupado, 0);
    chk("ab_rv", b1.resultado_valido, 0);
    step();
    chk("ab_rv2", b1.resultado_valido, 0);
    push1(8'h04);
    chk("ab_push_topo", b1.topo, 8'h04);
    chk("ab_push_nivel", b1.nivel, 1);
    limpar1();

    // reset during OPERA
    push1(8'h01);
    exec1(3'd0);
    push1(8'h02);
    exec1(3'd1);
    chk("rs_ocupado", b1.ocupado, 1);
    chk("rs_alu_a_set", b1.alu_a, 8'h01);
    reset_n = 1'b0;
    #1;
    chk("rs_nivel", b1.nivel, 0);
    chk("rs_topo", b1.topo, 0);
    chk("rs_ocupado0", b1.ocupado, 0);
    chk("rs_rv", b1.resultado_valido, 0);
    chk("rs_flags", {b1.erro_overflow, b1.erro_underflow}, 0);
    chk("rs_alu", {b1.alu_a, b1.alu_b, b1.alu_op}, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("rs_rv_after", b1.resultado_valido, 0);

    // LATENCIA_ALU=3 instance
    b3.dado_entrada = 8'h10; b3.enter_pulso = 1'b1;
    step();
    b3.dado_entrada = 8'h20;
    step();
    b3.enter_pulso = 1'b0;
    chk("l3_nivel2", b3.nivel, 2);
    q3.push_back(8'h30);
    b3.codigo_op = 3'd0; b3.executar_pulso = 1'b1;
    step();
    b3.executar_pulso = 1'b0;
    chk("l3_ocup_c1", b3.ocupado, 1);
    b3.dado_entrada = 8'h55; b3.enter_pulso = 1'b1;
    step();
    b3.enter_pulso = 1'b0;
    chk("l3_ocup_c2", b3.ocupado, 1);
    chk("l3_nivel_c2", b3.nivel, 2);
    b3.executar_pulso = 1'b1;
    step();
    b3.executar_pulso = 1'b0;
    chk("l3_ocup_c3", b3.ocupado, 1);
    chk("l3_nivel_c3", b3.nivel, 2);
    chk("l3_rv_c3", b3.resultado_valido, 0);
    step();
    chk("l3_ocup_done", b3.ocupado, 0);
    chk("l3_nivel_res", b3.nivel, 1);
    chk("l3_topo_res", b3.topo, 8'h30);
    chk("l3_rv", b3.resultado_valido, 1);
    step();
    chk("l3_rv_pulse", b3.resultado_valido, 0);

    step(); step();
    chk("q1_empty", q1.size(), 0);
    chk("q3_empty", q3.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
